// File: rtl/dump_mon_pkg.sv
// Shared types and result codes for the dump_on pulse monitor.
package dump_mon_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_RISE,
    S_MEAS_ON,
    S_MEAS_OFF,
    S_DONE
  } state_e;

  localparam logic [2:0] ERR_NONE        = 3'd0;
  localparam logic [2:0] ERR_ON_SHORT    = 3'd1;
  localparam logic [2:0] ERR_ON_LONG     = 3'd2;
  localparam logic [2:0] ERR_OFF_SHORT   = 3'd3;
  localparam logic [2:0] ERR_OFF_LONG    = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT     = 3'd5;
  localparam logic [2:0] ERR_HIGH_AT_ARM = 3'd6;

endpackage

// File: rtl/dump_edge_sync.sv
// Synchroniser for dump_on plus registered level/rise/fall, all three aligned
// to the same cycle so the FSM sees a consistent view of the waveform.
module dump_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic synced;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign synced = din;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;

      // Plain flop chain into the clk_sys domain.
      always_ff @(posedge clk_sys) begin
        if (rst) begin
          sync_q <= '0;
        end else begin
          sync_q[0] <= din;
          for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
      end

      assign synced = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // Edge-detect stage: level is the delayed copy, so rise/fall line up with it.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      level <= synced;
      rise  <= synced & ~level;
      fall  <= ~synced & level;
    end
  end

endmodule

// File: rtl/dump_on_monitor.sv
// Receive-side checker for the dump_on pulse protocol: arms on state_start,
// measures every on/off phase against limits, counts pulses, reports done.
module dump_on_monitor
  import dump_mon_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int EXP_PULSES  = 4,
  parameter int MIN_ON      = 10,
  parameter int MAX_ON      = 200,
  parameter int MIN_OFF     = 10,
  parameter int MAX_OFF     = 200,
  parameter int TIMEOUT     = 1000,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             state_start,
  input  logic             dump_on,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [2:0]       err_code,
  output logic [7:0]       pulse_cnt,
  output logic [CNT_W-1:0] last_on_w,
  output logic [CNT_W-1:0] last_off_w
);

  localparam logic [CNT_W-1:0] MIN_ON_L  = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] MAX_ON_L  = CNT_W'(MAX_ON);
  localparam logic [CNT_W-1:0] MIN_OFF_L = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] MAX_OFF_L = CNT_W'(MAX_OFF);
  localparam logic [CNT_W-1:0] TMO_L     = CNT_W'(TIMEOUT);
  localparam logic [7:0]       EXP_L     = 8'(EXP_PULSES);

  logic level, rise, fall;

  dump_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_sys (clk_sys),
    .rst     (rst),
    .din     (dump_on),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  state_e           state;
  logic             start_q;
  logic [CNT_W-1:0] len, timer;
  logic [CNT_W-1:0] len_inc, timer_inc;
  logic [7:0]       pulse_inc;
  logic             start_rise;
  logic             fin;
  logic [2:0]       fin_code;

  assign start_rise = state_start & ~start_q;
  assign len_inc    = (len == '1) ? len : len + 1'b1;
  assign timer_inc  = (timer == '1) ? timer : timer + 1'b1;
  assign pulse_inc  = pulse_cnt + 8'd1;

  // Decide whether this cycle ends the check, and with which code.
  always_comb begin
    fin      = 1'b0;
    fin_code = ERR_NONE;
    case (state)
      S_ARM: begin
        if (level) begin
          fin      = 1'b1;
          fin_code = ERR_HIGH_AT_ARM;
        end
      end
      S_WAIT_RISE: begin
        if (!rise && timer_inc == TMO_L) begin
          fin      = 1'b1;
          fin_code = ERR_TIMEOUT;
        end
      end
      S_MEAS_ON: begin
        if (fall) begin
          if (len < MIN_ON_L) begin
            fin      = 1'b1;
            fin_code = ERR_ON_SHORT;
          end else if (pulse_inc == EXP_L) begin
            fin      = 1'b1;
            fin_code = ERR_NONE;
          end
        end else if (len_inc > MAX_ON_L) begin
          fin      = 1'b1;
          fin_code = ERR_ON_LONG;
        end
      end
      S_MEAS_OFF: begin
        if (rise) begin
          if (len < MIN_OFF_L) begin
            fin      = 1'b1;
            fin_code = ERR_OFF_SHORT;
          end
        end else if (len_inc > MAX_OFF_L) begin
          fin      = 1'b1;
          fin_code = ERR_OFF_LONG;
        end
      end
      default: ;
    endcase
  end

  // Main FSM with registered outputs; a start rise overrides everything.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state      <= S_IDLE;
      start_q    <= 1'b0;
      len        <= '0;
      timer      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_code   <= ERR_NONE;
      pulse_cnt  <= '0;
      last_on_w  <= '0;
      last_off_w <= '0;
    end else begin
      start_q <= state_start;
      done    <= 1'b0;

      case (state)
        S_ARM: begin
          timer <= {{(CNT_W-1){1'b0}}, 1'b1};  // the arm cycle itself counts
          state <= S_WAIT_RISE;
        end
        S_WAIT_RISE: begin
          timer <= timer_inc;
          if (rise) begin
            state <= S_MEAS_ON;
            len   <= {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_MEAS_ON: begin
          if (fall) begin
            if (len >= MIN_ON_L) begin
              last_on_w <= len;
              pulse_cnt <= pulse_inc;
              state     <= S_MEAS_OFF;
              len       <= {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            len <= len_inc;
          end
        end
        S_MEAS_OFF: begin
          if (rise) begin
            if (len >= MIN_OFF_L) begin
              last_off_w <= len;
              state      <= S_MEAS_ON;
              len        <= {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            len <= len_inc;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: ;
      endcase

      if (fin) begin
        state    <= S_DONE;
        done     <= 1'b1;
        busy     <= 1'b0;
        err_code <= fin_code;
        pass     <= (fin_code == ERR_NONE);
      end

      if (start_rise) begin
        state      <= S_ARM;
        busy       <= 1'b1;
        done       <= 1'b0;
        pass       <= 1'b0;
        err_code   <= ERR_NONE;
        len        <= '0;
        timer      <= '0;
        pulse_cnt  <= '0;
        last_on_w  <= '0;
        last_off_w <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dump_on_monitor.sv
// Randomised and directed checks of dump_on_monitor against a phase-level model.
module tb_dump_on_monitor;

  localparam int EXP = 3, MIN_ON = 4, MAX_ON = 8, MIN_OFF = 4, MAX_OFF = 8;
  localparam int TMO = 20, SYNC = 2, CW = 16, LAT = SYNC + 2, NC = 200;

  logic          clk_sys = 1'b0;
  logic          rst, state_start, dump_on;
  logic          busy, done, pass;
  logic [2:0]    err_code;
  logic [7:0]    pulse_cnt;
  logic [CW-1:0] last_on_w, last_off_w;

  dump_on_monitor #(
    .CNT_W(CW), .EXP_PULSES(EXP), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON),
    .MIN_OFF(MIN_OFF), .MAX_OFF(MAX_OFF), .TIMEOUT(TMO), .SYNC_STAGES(SYNC)
  ) dut (
    .clk_sys(clk_sys), .rst(rst), .state_start(state_start), .dump_on(dump_on),
    .busy(busy), .done(done), .pass(pass), .err_code(err_code),
    .pulse_cnt(pulse_cnt), .last_on_w(last_on_w), .last_off_w(last_off_w)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic busy, done, pass; logic [2:0] err; logic [7:0] cnt; logic [15:0] on_w, off_w;
  } out_t;
  typedef struct packed {
    logic [15:0] ndone, cyc; logic pass; logic [2:0] err; logic [7:0] cnt; logic [15:0] on_w, off_w;
  } res_t;

  int   checks = 0, errors = 0;
  out_t olog [0:NC];
  bit   wave [0:NC-1];
  bit   strt [0:NC-1];
  bit   rstw [0:NC-1];

  function automatic void clear_stim();
    for (int c = 0; c < NC; c++) begin wave[c] = 0; strt[c] = 0; rstw[c] = 0; end
  endfunction

  // Arm at cycle s; pin pulses start at cycle a with the given on/off lengths.
  function automatic void put_seq(input int s, input int a, input int on_l[3], input int off_l[3]);
    int pos = a;
    strt[s] = 1;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < on_l[p]; k++) if (pos + k < NC) wave[pos+k] = 1;
      pos += on_l[p] + off_l[p];
    end
  endfunction

  // Phase-level reference: every verdict shows up LAT cycles after the pin cycle that decides it.
  function automatic res_t model(input int a, input int on_l[3], input int off_l[3]);
    res_t r = '0;
    int rise = a, cnt = 0, lon = 0, loff = 0, code = -1, at = 0;
    for (int p = 0; p < EXP && code < 0; p++) begin
      if (on_l[p] > MAX_ON)       begin code = 2; at = rise + MAX_ON; end
      else if (on_l[p] < MIN_ON)  begin code = 1; at = rise + on_l[p]; end
      else begin
        lon = on_l[p]; cnt++;
        if (cnt == EXP) begin code = 0; at = rise + on_l[p]; end
        else if (off_l[p] > MAX_OFF) begin code = 4; at = rise + on_l[p] + MAX_OFF; end
        else if (off_l[p] < MIN_OFF) begin code = 3; at = rise + on_l[p] + off_l[p]; end
        else begin loff = off_l[p]; rise += on_l[p] + off_l[p]; end
      end
    end
    r.ndone = 1; r.cyc = 16'(at + LAT); r.pass = (code == 0); r.err = 3'(code);
    r.cnt = 8'(cnt); r.on_w = 16'(lon); r.off_w = 16'(loff);
    return r;
  endfunction

  // Drive stimulus tables cycle by cycle; log outputs #1 after each edge.
  task automatic run_wave(input int n);
    olog[0] = '0;
    for (int c = 0; c < n; c++) begin
      rst = rstw[c]; dump_on = wave[c]; state_start = strt[c];
      @(posedge clk_sys); #1;
      olog[c+1] = {busy, done, pass, err_code, pulse_cnt, last_on_w, last_off_w};
    end
    rst = 0; dump_on = 0; state_start = 0;
  endtask

  function automatic res_t summarize(input int n);
    res_t r = '0;
    for (int c = 1; c <= n; c++) if (olog[c].done) begin
      if (r.ndone == 0) begin
        r.cyc = 16'(c); r.pass = olog[c].pass; r.err = olog[c].err;
        r.cnt = olog[c].cnt; r.on_w = olog[c].on_w; r.off_w = olog[c].off_w;
      end
      r.ndone++;
    end
    return r;
  endfunction

  int rnd_len_lo, rnd_len_hi;
  function automatic int rnd_len();
    if ($urandom_range(9, 0) < 7) return int'($urandom_range(MAX_ON, MIN_ON));
    return int'($urandom_range(12, 1));
  endfunction

  task automatic test_reset();
    rst = 1; state_start = 0; dump_on = 0;
    repeat (3) @(posedge clk_sys);
    #1;
    checks++;
    if ({busy, done, pass, err_code, pulse_cnt, last_on_w, last_off_w} !== 46'b0) begin
      errors++;
      $display("FAIL reset outputs got=%h exp=0", {busy, done, pass, err_code, pulse_cnt, last_on_w, last_off_w});
    end
    rst = 0;
    @(posedge clk_sys); #1;
  endtask

  task automatic test_pass();
    res_t got, exp;
    clear_stim(); put_seq(0, 3, '{6, 6, 6}, '{5, 5, 5});
    run_wave(60);
    got = summarize(60); exp = model(3, '{6, 6, 6}, '{5, 5, 5});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL pass_seq got=%p exp=%p", got, exp); end
    checks++;
    if ({olog[2].busy, olog[exp.cyc-1].busy, olog[exp.cyc].busy} !== 3'b110) begin
      errors++; $display("FAIL busy_window got=%b exp=110", {olog[2].busy, olog[exp.cyc-1].busy, olog[exp.cyc].busy});
    end
  endtask

  task automatic test_short_on();
    res_t got, exp;
    clear_stim(); put_seq(0, 3, '{3, 6, 6}, '{5, 5, 5});
    run_wave(60);
    got = summarize(60); exp = model(3, '{3, 6, 6}, '{5, 5, 5});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL on_short got=%p exp=%p", got, exp); end
  endtask

  task automatic test_long();
    res_t got, exp;
    clear_stim(); put_seq(0, 3, '{30, 6, 6}, '{5, 5, 5});
    run_wave(80);
    got = summarize(80); exp = model(3, '{30, 6, 6}, '{5, 5, 5});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL on_long got=%p exp=%p", got, exp); end
    clear_stim(); put_seq(0, 3, '{6, 6, 6}, '{9, 5, 5});
    run_wave(80);
    got = summarize(80); exp = model(3, '{6, 6, 6}, '{9, 5, 5});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL off_long got=%p exp=%p", got, exp); end
  endtask

  task automatic test_timeout();
    res_t got, exp;
    clear_stim(); strt[0] = 1;
    run_wave(60);
    got = summarize(60);
    exp = '0; exp.ndone = 1; exp.cyc = 16'(1 + TMO); exp.err = 3'd5;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL timeout got=%p exp=%p", got, exp); end
  endtask

  task automatic test_high_at_arm();
    res_t got, exp;
    clear_stim();
    for (int c = 0; c < 20; c++) wave[c] = 1;
    strt[4] = 1;
    run_wave(50);
    got = summarize(50);
    exp = '0; exp.ndone = 1; exp.cyc = 16'(6); exp.err = 3'd6;
    checks++;
    if (got !== exp) begin errors++; $display("FAIL high_at_arm got=%p exp=%p", got, exp); end
  endtask

  task automatic test_rearm();
    res_t got, exp;
    clear_stim(); put_seq(0, 3, '{6, 6, 6}, '{5, 5, 5});
    for (int c = 20; c < NC; c++) wave[c] = 0;
    put_seq(22, 30, '{6, 6, 6}, '{5, 5, 5});
    run_wave(100);
    checks++;
    if ({olog[21].cnt, olog[24].cnt, olog[24].on_w, olog[24].busy} !== {8'd1, 8'd0, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL rearm_clear got=%0d/%0d/%0d/%b exp=1/0/0/1", olog[21].cnt, olog[24].cnt, olog[24].on_w, olog[24].busy);
    end
    got = summarize(100); exp = model(30, '{6, 6, 6}, '{5, 5, 5});
    checks++;
    if (got !== exp) begin errors++; $display("FAIL rearm_seq got=%p exp=%p", got, exp); end
  endtask

  task automatic test_rst_mid();
    res_t got;
    clear_stim(); put_seq(0, 3, '{6, 6, 6}, '{5, 5, 5});
    rstw[9] = 1;
    run_wave(60);
    got = summarize(60);
    checks++;
    if ({olog[9].busy, olog[10], got.ndone} !== {1'b1, 46'b0, 16'd0}) begin
      errors++;
      $display("FAIL rst_mid got busy9=%b out10=%h ndone=%0d exp 1/0/0", olog[9].busy, olog[10], got.ndone);
    end
    test_pass();
  endtask

  task automatic test_random();
    res_t got, exp;
    int a, on_l[3], off_l[3];
    for (int it = 0; it < 40; it++) begin
      a = int'($urandom_range(10, 1));
      for (int p = 0; p < 3; p++) begin on_l[p] = rnd_len(); off_l[p] = rnd_len(); end
      clear_stim(); put_seq(0, a, on_l, off_l);
      run_wave(120);
      got = summarize(120); exp = model(a, on_l, off_l);
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random it=%0d a=%0d on=%p off=%p got=%p exp=%p", it, a, on_l, off_l, got, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_short_on();
    test_long();
    test_timeout();
    test_high_at_arm();
    test_rearm();
    test_rst_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
